adder_8bit_seq_ctrl: RTL and testbench
======================================

// Module: adder_8bit_seq_ctrl
// PURPOSE
//  Multi-precision add sequencer built around one shared 8-bit add slice (a+b+cin -> sum, cout).
//  Accepts NBYTES-wide operands over a valid/ready handshake and adds one byte per cycle, LSB first.
//  Chains each byte's carry into the next byte and returns the full result plus final carry.
//  Sits between a requester (e.g. ALU/accumulator) and the byte-wide adder datapath.
// PARAMETERS
//  NBYTES  4  operand width in bytes (>=1); W = 8*NBYTES (localparam)
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous reset, active low
//  in_valid   in   1  request valid
//  in_ready   out  1  block can accept a request
//  op_a       in   W  operand A
//  op_b       in   W  operand B
//  carry_in   in   1  initial carry into byte 0
//  out_valid  out  1  result valid
//  out_ready  in   1  consumer accepts result
//  result     out  W  sum[W-1:0]
//  carry_out  out  1  carry out of byte NBYTES-1
//  busy       out  1  high in RUN or DONE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, byte_idx=0, carry=0, operand/result regs=0;
//   in_ready=1 after release; out_valid=0, result=0, carry_out=0, busy=0.
//  FSM IDLE -> RUN -> DONE -> IDLE. in_ready = (state==IDLE); out_valid = (state==DONE).
//  IDLE: on in_valid (edge E0) latch op_a, op_b, carry_in; byte_idx=0; go RUN.
//  RUN: one byte per edge (E1..E_NBYTES): sum_k = a[k]+b[k]+c; c <= cout_k;
//   result byte k <= sum_k; byte_idx++. At byte_idx==NBYTES-1 go DONE.
//  Latency: out_valid rises NBYTES cycles after the accepting edge. NBYTES=1 -> one RUN cycle.
//  DONE: result/carry_out held stable until out_ready=1. out_ready=1 -> IDLE next edge.
//  Throughput: one transaction per NBYTES+2 cycles; no overlap of accept and drain.
//  in_valid outside IDLE: ignored, no capture. op_a/op_b may change after accept.
//  out_ready outside DONE: ignored.
//  Carry chain is exact modular arithmetic: {carry_out,result} = op_a + op_b + carry_in, W+1 bits.
//  byte_idx width = max(1,$clog2(NBYTES)); it never wraps past NBYTES-1.
//  Reset mid-RUN/DONE: transaction dropped, out_valid falls immediately (async), no partial result.
// CONFIGURATION
//  ADDSEQ_SUB_EN defined: extra input op_sub (1 bit, latched with the operands).
//   op_sub=1: each byte uses ~b and the chain starts with ~carry_in,
//   so result = op_a - op_b - carry_in (carry_in = borrow in);
//   carry_out = 1 means no borrow. op_sub=0 identical to add.
//  ADDSEQ_SUB_EN undefined: no op_sub port; add only.
// STRUCTURE
//  Package adder_seq_pkg: BYTE_W=8; state enum {IDLE,RUN,DONE}; op-code constants.
//  Sub-module adder_byte_slice: combinational 8-bit a+b+cin -> {cout,sum}, instanced once.
//  Top: FSM, byte_idx counter, operand shift regs, result reg, carry reg.
// TESTING (NBYTES=4)
//  1. 0x000000FF + 0x00000001, cin=0 -> result=0x00000100, cout=0; out_valid 4 cycles after accept.
//  2. 0xFFFFFFFF + 0x00000000, cin=1 -> result=0x00000000, cout=1 (full carry ripple).
//  3. Backpressure: out_ready=0 for 5 cycles -> result/cout stable, in_ready=0, in_valid ignored.
//  4. rst_n low after 2 RUN cycles -> out_valid=0, busy=0; after release in_ready=1;
//     next op 0x12345678 + 0x11111111 -> 0x23456789.
//  5. Back-to-back, out_ready=1, in_valid=1 -> accepts spaced exactly 6 cycles, both results correct.
//  6. ADDSEQ_SUB_EN, op_sub=1: 0x00000000 - 0x00000001, cin=0 -> 0xFFFFFFFF, cout=0;
//     5 - 3 -> 0x00000002, cout=1.

Source files
------------

// File: rtl/adder_seq_pkg.sv
// Shared definitions for the multi-precision add sequencer: byte width,
// FSM state encoding, operation codes and a small index-width helper.
package adder_seq_pkg;

  localparam int BYTE_W = 8;

  // Operation select values (subtract only reachable when ADDSEQ_SUB_EN is defined)
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter indexing n bytes; at least one bit so NBYTES=1 still has a counter
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_byte_slice.sv
// Combinational 8-bit add slice: {cout, sum} = a + b + cin.
// The sequencer time-shares a single instance across all operand bytes.
module adder_byte_slice
  import adder_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [BYTE_W:0] total;

  // Nine-bit sum so the carry falls out as the top bit
  assign total = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
  assign sum   = total[BYTE_W-1:0];
  assign cout  = total[BYTE_W];

endmodule

// File: rtl/adder_8bit_seq_ctrl.sv
// Multi-precision add sequencer: accepts NBYTES-wide operands over valid/ready,
// adds one byte per cycle LSB first through one shared byte slice, chaining the
// carry, and holds {carry_out, result} until the consumer takes it.
// Optional macro ADDSEQ_SUB_EN adds an op_sub input; when set the B operand is
// inverted and the chain starts from ~carry_in, giving op_a - op_b - carry_in
// with carry_out = 1 meaning no borrow.
module adder_8bit_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] op_a,
  input  logic [BYTE_W*NBYTES-1:0] op_b,
  input  logic                     carry_in,
`ifdef ADDSEQ_SUB_EN
  input  logic                     op_sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] result,
  output logic                     carry_out,
  output logic                     busy
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   byte_idx_reg;
  logic [W-1:0]       a_reg, b_reg, result_reg;
  logic               carry_reg;
  logic               sub_sel;
  logic               accept, run_active;
  logic [NBYTES-1:0]  byte_we;
  logic [BYTE_W-1:0]  slice_sum;
  logic               slice_cout;

`ifdef ADDSEQ_SUB_EN
  assign sub_sel = op_sub;
`else
  assign sub_sel = OP_ADD;
`endif

  assign accept     = (state_reg == IDLE) && in_valid;
  assign run_active = (state_reg == RUN);

  // Operands shift down a byte per RUN cycle, so the slice always sees bits [7:0]
  adder_byte_slice u_slice (
    .a    (a_reg[BYTE_W-1:0]),
    .b    (b_reg[BYTE_W-1:0]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // One write enable per result byte, selected by the running byte index
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_byte_we
      assign byte_we[gi] = run_active && (byte_idx_reg == IDX_W'(gi));
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (byte_idx_reg == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture/shift, carry chain and byte index; subtract folds into capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      carry_reg    <= 1'b0;
      byte_idx_reg <= '0;
    end else if (accept) begin
      a_reg        <= op_a;
      b_reg        <= (sub_sel == OP_SUB) ? ~op_b : op_b;
      carry_reg    <= (sub_sel == OP_SUB) ? ~carry_in : carry_in;
      byte_idx_reg <= '0;
    end else if (run_active) begin
      a_reg     <= a_reg >> BYTE_W;
      b_reg     <= b_reg >> BYTE_W;
      carry_reg <= slice_cout;
      if (byte_idx_reg != LAST_IDX) byte_idx_reg <= byte_idx_reg + 1'b1;
    end
  end

  // Result bytes written in place as the chain reaches them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        if (byte_we[i]) result_reg[i*BYTE_W +: BYTE_W] <= slice_sum;
      end
    end
  end

  assign result    = result_reg;
  assign carry_out = carry_reg;

endmodule

// File: tb/tb_adder_8bit_seq_ctrl.sv
// Directed bench for adder_8bit_seq_ctrl (NBYTES=4): single carry, full ripple,
// backpressure, reset mid-run, back-to-back throughput and (with ADDSEQ_SUB_EN)
// subtraction. Inputs driven and outputs sampled on the falling edge.
module tb_adder_8bit_seq_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         carry_in = 1'b0;
  logic         op_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry_out;
  logic         busy;

  int n_vec = 0;
  int n_bad = 0;

  adder_8bit_seq_ctrl #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .carry_in  (carry_in),
`ifdef ADDSEQ_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge; returns at the falling edge after acceptance
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'(1));
    op_a = a; op_b = b; carry_in = cin; op_sub = sub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op_a = 32'hDEADBEEF; op_b = 32'hCAFEF00D; carry_in = ~cin; op_sub = ~sub;
    check("accept_busy", 64'(busy), 64'(1));
    check("accept_in_ready", 64'(in_ready), 64'(0));
  endtask

  // Count cycles from accept to out_valid (bounded) and check latency
  task automatic wait_done();
    int cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", 64'(cnt), 64'(NB));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_out_valid", 64'(out_valid), 64'(0));
    check("drain_in_ready", 64'(in_ready), 64'(1));
  endtask

  task automatic full_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub,
                         input logic [W-1:0] exp_res, input logic exp_cout);
    start_op(a, b, cin, sub);
    wait_done();
    check({tag, "_result"}, 64'(result), 64'(exp_res));
    check({tag, "_cout"}, 64'(carry_out), 64'(exp_cout));
    $display("txn %s: %08h op %08h cin=%0d -> %08h cout=%0d", tag, a, b, cin, result, carry_out);
    drain();
  endtask

  initial begin
    // Reset state
    #12;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_result", 64'(result), 64'(0));
    check("reset_cout", 64'(carry_out), 64'(0));

    // 1. Single carry across byte boundary
    full_op("t1", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0);

    // 2. Full ripple through all bytes
    full_op("t2", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1);

    // 3. Backpressure: hold out_ready low 5 cycles, poke in_valid
    start_op(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0);
    wait_done();
    in_valid = 1'b1; op_a = 32'h11111111; op_b = 32'h22222222;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_result", 64'(result), 64'(32'h00000000));
      check("bp_cout", 64'(carry_out), 64'(1));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
    end
    in_valid = 1'b0;
    $display("txn t3: backpressure held %08h cout=%0d", result, carry_out);
    drain();

    // 4. Reset after two RUN cycles
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_result", 64'(result), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_in_ready", 64'(in_ready), 64'(1));
    $display("txn t4: reset mid-run, transaction dropped");
    full_op("t4", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0);

    // 5. Back-to-back with out_ready held high
    begin
      logic [W-1:0] va [2];
      logic [W-1:0] vb [2];
      logic         vc [2];
      logic [W-1:0] er [2];
      logic         ec [2];
      int acc_cyc [2];
      int n_acc = 0;
      int n_done = 0;
      va[0] = 32'h01020304; vb[0] = 32'h10203040; vc[0] = 1'b0;
      er[0] = 32'h11223344; ec[0] = 1'b0;
      va[1] = 32'h80000000; vb[1] = 32'h80000000; vc[1] = 1'b1;
      er[1] = 32'h00000001; ec[1] = 1'b1;
      acc_cyc[0] = 0; acc_cyc[1] = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 14; cyc++) begin
        @(negedge clk);
        if (out_valid && n_done < 2) begin
          check("b2b_result", 64'(result), 64'(er[n_done]));
          check("b2b_cout", 64'(carry_out), 64'(ec[n_done]));
          $display("txn t5.%0d: %08h cout=%0d", n_done, result, carry_out);
          n_done++;
        end
        if (in_ready && n_acc < 2) begin
          op_a = va[n_acc]; op_b = vb[n_acc]; carry_in = vc[n_acc]; op_sub = 1'b0;
          in_valid = 1'b1;
          acc_cyc[n_acc] = cyc;
          n_acc++;
        end else if (n_acc >= 2) begin
          in_valid = 1'b0;
        end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("b2b_accepts", 64'(n_acc), 64'(2));
      check("b2b_done", 64'(n_done), 64'(2));
      check("b2b_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'(NB + 2));
    end

`ifdef ADDSEQ_SUB_EN
    // 6. Subtraction
    full_op("t6a", 32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0);
    full_op("t6b", 32'h00000005, 32'h00000003, 1'b0, 1'b1, 32'h00000002, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
